// File: rtl/m_seq_burst_ctrl.sv
// Burst controller for a maximal-length PN source.
// A programmable seed drives an internal Fibonacci LFSR. Bits leave over a
// valid/ready stream with last-bit marking, plus one-cycle status pulses for
// completion, abort, period wrap and a rejected all-zero seed.
module m_seq_burst_ctrl #(
    parameter int unsigned N     = 4,
    parameter logic [N-1:0] POLY = 4'b1100,
    parameter logic [N-1:0] SEED = 4'b1000,
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_ld,
    input  logic [N-1:0]     seed_in,
    input  logic             start,
    input  logic [LEN_W-1:0] burst_len,
    input  logic             abort,
    output logic             bit_out,
    output logic             bit_valid,
    input  logic             bit_ready,
    output logic             bit_last,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             period_wrap,
    output logic             err_zero
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [N-1:0]     lfsr;
    logic [N-1:0]     seed_reg;
    logic [N-1:0]     start_seed;
    logic [LEN_W-1:0] cnt;

    logic             hs;
    logic             fb;
    logic [N-1:0]     lfsr_adv;
    logic [N-1:0]     eff_seed;
    logic             seed_ok;

    // Feedback, advanced LFSR value, handshake and the seed a start would use
    always_comb begin
        fb = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            fb = fb ^ (lfsr[i] & POLY[N-1-i]);
        end
        lfsr_adv = {fb, lfsr[N-1:1]};
        hs       = (state == RUN) && bit_valid && bit_ready;
        seed_ok  = (seed_in != '0);
        // A non-zero seed loaded together with start applies to that burst
        eff_seed = (seed_ld && seed_ok) ? seed_in : seed_reg;
    end

    // Controller FSM with registered stream and status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            lfsr        <= SEED;
            seed_reg    <= SEED;
            start_seed  <= SEED;
            cnt         <= '0;
            bit_out     <= 1'b0;
            bit_valid   <= 1'b0;
            bit_last    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            period_wrap <= 1'b0;
            err_zero    <= 1'b0;
        end else begin
            done        <= 1'b0;
            aborted     <= 1'b0;
            period_wrap <= 1'b0;
            err_zero    <= 1'b0;
            case (state)
                IDLE: begin
                    if (seed_ld) begin
                        if (seed_ok) begin
                            seed_reg <= seed_in;
                        end else begin
                            err_zero <= 1'b1;
                        end
                    end
                    if (start) begin
                        if (burst_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            state      <= RUN;
                            lfsr       <= eff_seed;
                            start_seed <= eff_seed;
                            cnt        <= burst_len;
                            bit_valid  <= 1'b1;
                            busy       <= 1'b1;
                            bit_out    <= eff_seed[0];
                            bit_last   <= (burst_len == LEN_W'(1));
                        end
                    end
                end
                RUN: begin
                    if (hs) begin
                        lfsr <= lfsr_adv;
                        cnt  <= cnt - LEN_W'(1);
                        if (lfsr_adv == start_seed) begin
                            period_wrap <= 1'b1;
                        end
                    end
                    if (abort) begin
                        // Abort takes priority over a simultaneous final handshake
                        state     <= IDLE;
                        aborted   <= 1'b1;
                        bit_valid <= 1'b0;
                        busy      <= 1'b0;
                        bit_out   <= 1'b0;
                        bit_last  <= 1'b0;
                    end else if (hs) begin
                        if (cnt == LEN_W'(1)) begin
                            state     <= IDLE;
                            done      <= 1'b1;
                            bit_valid <= 1'b0;
                            busy      <= 1'b0;
                            bit_out   <= 1'b0;
                            bit_last  <= 1'b0;
                        end else begin
                            bit_out  <= lfsr_adv[0];
                            bit_last <= (cnt == LEN_W'(2));
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m_seq_burst_ctrl.sv
// Directed self-checking bench for m_seq_burst_ctrl.
module tb_m_seq_burst_ctrl;

    logic        clk;
    logic        rst;
    logic        seed_ld;
    logic [3:0]  seed_in;
    logic        start;
    logic [15:0] burst_len;
    logic        abort;
    logic        bit_out;
    logic        bit_valid;
    logic        bit_ready;
    logic        bit_last;
    logic        busy;
    logic        done;
    logic        aborted;
    logic        period_wrap;
    logic        err_zero;

    int n_err = 0;
    int n_chk = 0;

    // Hand-traced stream from seed 4'b1000; state 4'b0001 is element 14
    int pn [15] = '{0, 0, 0, 1, 0, 0, 1, 1, 0, 1, 0, 1, 1, 1, 1};

    m_seq_burst_ctrl dut (
        .clk(clk), .rst(rst), .seed_ld(seed_ld), .seed_in(seed_in),
        .start(start), .burst_len(burst_len), .abort(abort),
        .bit_out(bit_out), .bit_valid(bit_valid), .bit_ready(bit_ready),
        .bit_last(bit_last), .busy(busy), .done(done), .aborted(aborted),
        .period_wrap(period_wrap), .err_zero(err_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] outs();
        return {bit_out, bit_valid, bit_last, busy, done, aborted, period_wrap, err_zero};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input int len);
        start     = 1'b1;
        burst_len = 16'(len);
        tick();
        start     = 1'b0;
    endtask

    // Checks n bits taken with ready held high; offset selects the seed position
    task automatic stream(input int n, input int off, input int len);
        bit_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            check_eq("valid", 32'(bit_valid), 32'd1);
            check_eq("bit", 32'(bit_out), 32'(pn[(off + i) % 15]));
            check_eq("last", 32'(bit_last), 32'(i == len - 1));
            tick();
        end
    endtask

    task automatic run_full(input int len, input int off);
        start_burst(len);
        stream(len, off, len);
        check_eq("end_done", 32'(done), 32'd1);
        check_eq("end_valid", 32'(bit_valid), 32'd0);
        check_eq("end_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int hs;
        int wraps;
        logic rdy;

        rst = 1'b0; seed_ld = 1'b0; seed_in = '0; start = 1'b0;
        burst_len = '0; abort = 1'b0; bit_ready = 1'b0;

        // 1: reset values, then a full 15-bit period
        #3;
        check_eq("rst_outs", 32'(outs()), 32'd0);
        #20;
        check_eq("rst_outs_clk", 32'(outs()), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check_eq("post_rst_outs", 32'(outs()), 32'd0);
        run_full(15, 0);
        check_eq("t1_wrap", 32'(period_wrap), 32'd1);
        tick();
        check_eq("t1_done_pulse", 32'(done), 32'd0);
        check_eq("t1_wrap_pulse", 32'(period_wrap), 32'd0);

        // 2: 20 bits with ready toggling every cycle
        bit_ready = 1'b0;
        start_burst(20);
        hs = 0; wraps = 0; rdy = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (period_wrap) wraps++;
            if (!bit_valid) break;
            check_eq("t2_bit", 32'(bit_out), 32'(pn[hs % 15]));
            check_eq("t2_last", 32'(bit_last), 32'(hs == 19));
            rdy = ~rdy;
            bit_ready = rdy;
            if (rdy) hs++;
            tick();
        end
        check_eq("t2_handshakes", 32'(hs), 32'd20);
        check_eq("t2_wraps", 32'(wraps), 32'd1);
        check_eq("t2_done", 32'(done), 32'd1);
        bit_ready = 1'b0;
        tick();

        // 3: load 0001, then a rejected zero seed keeps it
        seed_ld = 1'b1; seed_in = 4'b0001;
        tick();
        seed_ld = 1'b0;
        check_eq("t3_no_err", 32'(err_zero), 32'd0);
        seed_ld = 1'b1; seed_in = 4'b0000;
        tick();
        seed_ld = 1'b0;
        check_eq("t3_err_zero", 32'(err_zero), 32'd1);
        tick();
        check_eq("t3_err_pulse", 32'(err_zero), 32'd0);
        // From 0001: bit 1, then 1000 and 0100 give 0, 0
        run_full(3, 14);
        tick();

        // 4: abort after the 4th handshake, then restart from seed_reg
        start_burst(10);
        stream(4, 14, 10);
        abort = 1'b1;
        bit_ready = 1'b0;
        tick();
        abort = 1'b0;
        check_eq("t4_aborted", 32'(aborted), 32'd1);
        check_eq("t4_no_done", 32'(done), 32'd0);
        check_eq("t4_busy", 32'(busy), 32'd0);
        check_eq("t4_valid", 32'(bit_valid), 32'd0);
        tick();
        check_eq("t4_abort_pulse", 32'(aborted), 32'd0);
        check_eq("t4_done_later", 32'(done), 32'd0);
        run_full(3, 14);
        tick();

        // 5: zero-length burst, then start ignored while busy
        start = 1'b1; burst_len = 16'd0;
        tick();
        start = 1'b0;
        check_eq("t5_done", 32'(done), 32'd1);
        check_eq("t5_valid", 32'(bit_valid), 32'd0);
        check_eq("t5_busy", 32'(busy), 32'd0);
        tick();
        check_eq("t5_done_pulse", 32'(done), 32'd0);
        check_eq("t5_valid2", 32'(bit_valid), 32'd0);
        start_burst(5);
        bit_ready = 1'b1;
        start = 1'b1; burst_len = 16'd2;
        hs = 0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            if (!bit_valid) break;
            hs++;
            tick();
            start = 1'b0;
        end
        start = 1'b0;
        check_eq("t5_count", 32'(hs), 32'd5);
        check_eq("t5_end_busy", 32'(busy), 32'd0);
        tick();

        // 6: reset mid-burst clears outputs at once and restores the seed
        start_burst(10);
        stream(2, 14, 10);
        rst = 1'b0;
        #2;
        check_eq("t6_async_outs", 32'(outs()), 32'd0);
        #2;
        rst = 1'b1;
        tick();
        check_eq("t6_after_outs", 32'(outs()), 32'd0);
        run_full(4, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
